// File: rtl/store_narrow_unit.sv
// -----------------------------------------------------------------------------
// store_narrow_unit
//
// Purpose:
//   Narrows a 32-bit register value to byte, halfword or word width for
//   sb/sh/sw stores. The kept bytes go out big-endian on a byte-wide
//   data-memory write port, one byte per write/ack handshake. The unit pulses
//   done when the last byte is acked. It pulses err when a request is
//   misaligned or has an illegal size, or when a byte is not acked within
//   TIMEOUT cycles.
//
// Parameters:
//   ADDR_W   width of request and memory addresses
//   TIMEOUT  max cycles mem_we may stay high for one byte without mem_ack
//            before the store is aborted (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  store request present
//   req_ready  unit can accept a request (high only in IDLE)
//   req_addr   byte address of the store
//   req_data   register value to store (upper bits dropped per size)
//   req_size   00 byte, 01 halfword, 10 word, 11 illegal
//   mem_we     byte write strobe to memory
//   mem_addr   byte address of the current write
//   mem_wdata  byte being written
//   mem_ack    memory accepted the current byte
//   done       one-cycle pulse: store completed
//   err        one-cycle pulse: request rejected or aborted
// -----------------------------------------------------------------------------
module store_narrow_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  // Bytes still waiting to be presented, MSB first.
  logic [23:0]       shift_q, shift_d;
  // Number of bytes left after the one currently presented.
  logic [1:0]        left_q, left_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Request decode: legality, left-justified data and byte count.
  logic              req_legal;
  logic [31:0]       req_just;
  logic [1:0]        req_left;

  always_comb begin
    req_legal = 1'b0;
    req_just  = req_data;
    req_left  = 2'd0;
    case (req_size)
      2'b00: begin
        req_legal = 1'b1;
        req_just  = {req_data[7:0], 24'h000000};
        req_left  = 2'd0;
      end
      2'b01: begin
        req_legal = ~req_addr[0];
        req_just  = {req_data[15:0], 16'h0000};
        req_left  = 2'd1;
      end
      2'b10: begin
        req_legal = (req_addr[1:0] == 2'b00);
        req_just  = req_data;
        req_left  = 2'd3;
      end
      default: begin
        req_legal = 1'b0;
      end
    endcase
  end

  // Unlike the other outputs, req_ready is decoded from state, so a new
  // request can be accepted in the same cycle that done pulses.
  assign req_ready = (state_q == S_IDLE);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    shift_d     = shift_q;
    left_d      = left_q;
    to_d        = to_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_legal) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_just[31:24];
            shift_d     = req_just[23:0];
            left_d      = req_left;
            to_d        = '0;
          end else begin
            // Rejected: stay idle, no write, only the error pulse.
            err_d = 1'b1;
          end
        end
      end

      S_WRITE: begin
        if (mem_ack) begin
          to_d = '0;
          if (left_q == 2'd0) begin
            state_d  = S_IDLE;
            mem_we_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            // Present the next byte in the very next cycle; mem_we stays high.
            mem_addr_d  = mem_addr_q + ADDR_W'(1);
            mem_wdata_d = shift_q[23:16];
            shift_d     = {shift_q[15:0], 8'h00};
            left_d      = left_q - 2'd1;
          end
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle without ack: drop the remaining bytes.
          state_d  = S_IDLE;
          mem_we_d = 1'b0;
          err_d    = 1'b1;
          left_d   = 2'd0;
          to_d     = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      shift_q     <= 24'h000000;
      left_q      <= 2'd0;
      to_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      to_q        <= to_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// -----------------------------------------------------------------------------
// tb_store_narrow_unit
//
// Self-checking bench for store_narrow_unit. A reference model lists the
// expected (address, byte) writes of each request from the store rules:
// byte k of an n-byte store goes to addr+k and is the k-th most significant
// kept byte. It also predicts accept/reject and timeout. The bench acts as
// the memory, acks each byte after a chosen delay and checks every cycle at
// the falling edge.
// -----------------------------------------------------------------------------
module tb_store_narrow_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic              done;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  store_narrow_unit #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flags are packed as {mem_we, done, err, req_ready}.
  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, 32'({mem_we, done, err, req_ready}), 32'(exp));
  endtask

  // Idle cycles with random, ignored mem_ack. Entered and left at a negedge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      mem_ack   = 1'($urandom);
      @(negedge clk);
      check_flags("idle_flags", 4'b0001);
    end
  endtask

  // One store transaction. delay >= 0: cycles before ack for every byte;
  // delay < 0: random per-byte delay, occasionally long enough to time out.
  // Entered and left at a negedge; the final negedge is the done/err cycle.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input int delay);
    int          n;
    bit          legal;
    int          d;
    logic [7:0]  exp_b[$];
    logic [31:0] ea;

    case (size)
      2'b00:   begin n = 1; legal = 1'b1; end
      2'b01:   begin n = 2; legal = (addr[0] == 1'b0); end
      2'b10:   begin n = 4; legal = (addr[1:0] == 2'b00); end
      default: begin n = 0; legal = 1'b0; end
    endcase
    for (int k = 0; k < n; k++) exp_b.push_back(8'(data >> (8 * (n - 1 - k))));

    check("ready_at_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_size  = size;
    mem_ack   = 1'b0;
    @(negedge clk);
    // Post-accept changes on the request port must not matter.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_size  = 2'($urandom);

    if (!legal) begin
      check_flags("reject_flags", 4'b0011);
      mem_ack = 1'($urandom);
      return;
    end

    for (int k = 0; k < n; k++) begin
      if (delay >= 0) d = delay;
      else if ($urandom_range(0, 39) == 0) d = TIMEOUT + 3;
      else d = $urandom_range(0, 3);
      ea = addr + 32'(k);
      for (int w = 0; w <= d && w < TIMEOUT; w++) begin
        check_flags("write_flags", 4'b1000);
        check("write_addr", mem_addr, ea);
        check("write_data", 32'(mem_wdata), 32'(exp_b[k]));
        mem_ack = (w == d);
        @(negedge clk);
      end
      if (d >= TIMEOUT) begin
        check_flags("timeout_flags", 4'b0011);
        mem_ack = 1'($urandom);
        return;
      end
    end
    check_flags("done_flags", 4'b0101);
    mem_ack = 1'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = 2'b00;
    mem_ack   = 1'b0;

    // Reset state.
    @(negedge clk);
    check_flags("reset_flags", 4'b0001);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_wdata", 32'(mem_wdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Directed cases.
    do_store(32'h0000_0013, 32'hDEAD_BEEF, 2'b00, 0);
    idle(2);
    do_store(32'h0000_0100, 32'h1234_5678, 2'b10, 0);
    idle(1);
    do_store(32'h0000_0022, 32'hFFFF_A55A, 2'b01, 3);
    idle(1);
    do_store(32'h0000_0102, 32'h1111_2222, 2'b10, 0);
    idle(1);
    do_store(32'h0000_0011, 32'h3333_4444, 2'b01, 0);
    idle(1);
    do_store(32'h0000_0040, 32'h5555_6666, 2'b11, 0);
    idle(1);
    // Timeout: no ack at all, then a normal byte store right behind it.
    do_store(32'h0000_0300, 32'hCAFE_F00D, 2'b10, TIMEOUT);
    do_store(32'h0000_0307, 32'h0000_00A7, 2'b00, 0);
    idle(1);
    // Ack on the last cycle before the timeout still succeeds.
    do_store(32'h0000_0400, 32'h0000_BEEF, 2'b01, TIMEOUT - 1);
    // Back-to-back: accepted in the done cycle, including top-of-space word.
    do_store(32'hFFFF_FFFC, 32'h89AB_CDEF, 2'b10, 0);
    do_store(32'h0000_0500, 32'h0102_0304, 2'b10, 1);
    idle(2);

    // Reset during the second byte of a word store.
    req_valid = 1'b1;
    req_addr  = 32'h0000_0200;
    req_data  = 32'hA1B2_C3D4;
    req_size  = 2'b10;
    mem_ack   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("rst_byte2_addr", mem_addr, 32'h0000_0201);
    check("rst_byte2_data", 32'(mem_wdata), 32'h0000_00B2);
    #2 rst_n = 1'b0;
    #1;
    check_flags("async_rst_flags", 4'b0001);
    check("async_rst_addr", mem_addr, 32'h0);
    check("async_rst_wdata", 32'(mem_wdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    do_store(32'h0000_0210, 32'h0000_0077, 2'b00, 0);
    idle(1);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFC;
      do_store(a, $urandom, sz, -1);
      idle($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
